// File: rtl/rv32_d_issue_queue.sv
// In-order decode-to-execute issue queue with an integer/FP register scoreboard.
// The head issues only when none of its used sources or its destination is still pending a writeback.
module rv32_d_issue_queue #(
  parameter int PAYLOAD_W = 256,
  parameter int DEPTH     = 4,
  parameter int FP_EN     = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         flush_i,
  input  logic                         enq_valid_i,
  output logic                         enq_ready_o,
  input  logic [PAYLOAD_W-1:0]         enq_payload_i,
  input  logic                         enq_wr_i,
  input  logic [4:0]                   enq_rd_i,
  input  logic                         enq_rd_fp_i,
  input  logic [14:0]                  enq_rs_i,
  input  logic [2:0]                   enq_rs_used_i,
  input  logic [2:0]                   enq_rs_fp_i,
  output logic                         deq_valid_o,
  input  logic                         deq_ready_i,
  output logic [PAYLOAD_W-1:0]         deq_payload_o,
  input  logic                         wb_valid_i,
  input  logic [4:0]                   wb_rd_i,
  input  logic                         wb_fp_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         hazard_o
);

  localparam int  PW    = $clog2(DEPTH);
  localparam int  CW    = $clog2(DEPTH+1);
  localparam bit  FP_ON = (FP_EN != 0);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic                 wr;
    logic [4:0]           rd;
    logic                 rd_fp;
    logic [14:0]          rs;
    logic [2:0]           rs_used;
    logic [2:0]           rs_fp;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     busy_int_q, busy_int_d, busy_fp_q, busy_fp_d;

  entry_t          head;
  entry_t          enq_entry;
  logic            empty, blocked, enq_fire, deq_fire, wb_f;

  // A register still counts as pending unless a writeback to the same file and index lands this cycle.
  function automatic logic reg_pending(input logic [4:0]  idx,
                                       input logic        fp,
                                       input logic [31:0] b_int,
                                       input logic [31:0] b_fp,
                                       input logic        wb_v,
                                       input logic [4:0]  wb_idx,
                                       input logic        wb_file);
    logic hit;
    hit = fp ? b_fp[idx] : b_int[idx];
    if (wb_v && (wb_idx == idx) && (wb_file == fp)) hit = 1'b0;
    return hit;
  endfunction

  assign empty       = (count_q == '0);
  assign head        = mem_q[rptr_q];
  assign wb_f        = wb_fp_i & FP_ON;
  assign enq_ready_o = (count_q != CW'(DEPTH));
  assign enq_fire    = enq_valid_i & enq_ready_o;
  assign deq_valid_o = ~empty & ~blocked;
  assign deq_fire    = deq_valid_o & deq_ready_i;
  assign hazard_o    = ~empty & blocked;
  assign count_o     = count_q;
  assign deq_payload_o = empty ? '0 : head.payload;

  assign enq_entry = '{payload: enq_payload_i, wr: enq_wr_i, rd: enq_rd_i, rd_fp: enq_rd_fp_i & FP_ON,
                       rs: enq_rs_i, rs_used: enq_rs_used_i, rs_fp: enq_rs_fp_i & {3{FP_ON}}};

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    blocked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (head.rs_used[i] &&
          reg_pending(head.rs[i*5 +: 5], head.rs_fp[i], busy_int_q, busy_fp_q, wb_valid_i, wb_rd_i, wb_f))
        blocked = 1'b1;
    end
    if (head.wr && reg_pending(head.rd, head.rd_fp, busy_int_q, busy_fp_q, wb_valid_i, wb_rd_i, wb_f))
      blocked = 1'b1;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) begin
        mem_d[wptr_q] = enq_entry;
        wptr_d        = wptr_q + PW'(1);
      end
      if (deq_fire) rptr_d = rptr_q + PW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Clear first, then set, so an issue and a writeback to the same register leave it busy.
  // A flush cancels the same-cycle issue, so it must not mark a destination busy either.
  always_comb begin
    busy_int_d = busy_int_q;
    busy_fp_d  = busy_fp_q;
    if (wb_valid_i) begin
      if (wb_f) busy_fp_d[wb_rd_i]  = 1'b0;
      else      busy_int_d[wb_rd_i] = 1'b0;
    end
    if (deq_fire && !flush_i && head.wr) begin
      if (head.rd_fp) busy_fp_d[head.rd]  = 1'b1;
      else            busy_int_d[head.rd] = 1'b1;
    end
    busy_int_d[0] = 1'b0;
    if (!FP_ON) busy_fp_d = '0;
  end

  // NOTE: the storage array is reset as well, because the empty-queue payload and head flags must read 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      mem_q      <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      busy_int_q <= '0;
      busy_fp_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      busy_int_q <= busy_int_d;
      busy_fp_q  <= busy_fp_d;
    end
  end

endmodule

// File: tb/tb_rv32_d_issue_queue.sv
// Directed bench for rv32_d_issue_queue: stimulus pushes expected payloads, a negedge monitor checks issue order.
module tb_rv32_d_issue_queue;

  localparam int PAYLOAD_W = 256;
  localparam int DEPTH     = 4;
  localparam int CW        = $clog2(DEPTH+1);

  logic                 clk_i = 1'b0;
  logic                 rst_n_i;
  logic                 flush_i;
  logic                 enq_valid_i;
  logic                 enq_ready_o;
  logic [PAYLOAD_W-1:0] enq_payload_i;
  logic                 enq_wr_i;
  logic [4:0]           enq_rd_i;
  logic                 enq_rd_fp_i;
  logic [14:0]          enq_rs_i;
  logic [2:0]           enq_rs_used_i;
  logic [2:0]           enq_rs_fp_i;
  logic                 deq_valid_o;
  logic                 deq_ready_i;
  logic [PAYLOAD_W-1:0] deq_payload_o;
  logic                 wb_valid_i;
  logic [4:0]           wb_rd_i;
  logic                 wb_fp_i;
  logic [CW-1:0]        count_o;
  logic                 hazard_o;

  int checks   = 0;
  int failures = 0;
  logic [PAYLOAD_W-1:0] exp_q [$];

  rv32_d_issue_queue #(.PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .FP_EN(1)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o), .enq_payload_i(enq_payload_i),
    .enq_wr_i(enq_wr_i), .enq_rd_i(enq_rd_i), .enq_rd_fp_i(enq_rd_fp_i),
    .enq_rs_i(enq_rs_i), .enq_rs_used_i(enq_rs_used_i), .enq_rs_fp_i(enq_rs_fp_i),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i), .deq_payload_o(deq_payload_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_fp_i(wb_fp_i),
    .count_o(count_o), .hazard_o(hazard_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [PAYLOAD_W-1:0] act, input logic [PAYLOAD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PAYLOAD_W-1:0] mk(input int i);
    return {8{32'hA500_0000 | 32'(i)}};
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_enq(input logic [PAYLOAD_W-1:0] p, input logic wr, input logic [4:0] rd,
                         input logic rd_fp, input logic [14:0] rs, input logic [2:0] used,
                         input logic [2:0] rs_fp);
    enq_valid_i   = 1'b1;
    enq_payload_i = p;
    enq_wr_i      = wr;
    enq_rd_i      = rd;
    enq_rd_fp_i   = rd_fp;
    enq_rs_i      = rs;
    enq_rs_used_i = used;
    enq_rs_fp_i   = rs_fp;
  endtask

  task automatic enq_off();
    set_enq('0, 1'b0, 5'd0, 1'b0, 15'd0, 3'b000, 3'b000);
    enq_valid_i = 1'b0;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd, input logic fp);
    wb_valid_i = v;
    wb_rd_i    = rd;
    wb_fp_i    = fp;
  endtask

  // Monitor: mid-cycle, retire the expected head on a dequeue and record accepted enqueues.
  always @(negedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      exp_q.delete();
    end else begin
      if (deq_valid_o && deq_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL deq_unexpected: got %h expected no issue", deq_payload_o);
        end else begin
          check("deq_payload", deq_payload_o, exp_q.pop_front());
        end
      end
      if (enq_valid_i && enq_ready_o) exp_q.push_back(enq_payload_i);
    end
  end

  initial begin
    rst_n_i = 1'b0;
    flush_i = 1'b0;
    deq_ready_i = 1'b0;
    enq_off();
    wb(1'b0, 5'd0, 1'b0);
    #2;
    check("rst_enq_ready", enq_ready_o, 1);
    check("rst_deq_valid", deq_valid_o, 0);
    check("rst_hazard", hazard_o, 0);
    check("rst_count", count_o, 0);
    check("rst_payload", deq_payload_o, 0);
    cyc();
    rst_n_i = 1'b1;

    // Fill to DEPTH with no consumer, then drain in order.
    for (int i = 0; i < 5; i++) begin
      set_enq(mk(i), 1'b0, 5'd0, 1'b0, 15'd0, 3'b000, 3'b000);
      settle();
      check("fill_ready", enq_ready_o, (i < 4) ? 1 : 0);
      cyc();
    end
    enq_off();
    check("fill_count", count_o, 4);
    check("fill_not_ready", enq_ready_o, 0);
    deq_ready_i = 1'b1;
    repeat (4) cyc();
    deq_ready_i = 1'b0;
    settle();
    check("drain_count", count_o, 0);
    check("drain_payload_zero", deq_payload_o, 0);
    check("drain_deq_valid", deq_valid_o, 0);

    // RAW: writer x5 issues, reader of x5 stalls until the writeback cycle.
    set_enq(mk(10), 1'b1, 5'd5, 1'b0, 15'd0, 3'b000, 3'b000);
    cyc();
    set_enq(mk(11), 1'b0, 5'd0, 1'b0, 15'd5, 3'b001, 3'b000);
    cyc();
    enq_off();
    deq_ready_i = 1'b1;
    settle();
    check("raw_writer_valid", deq_valid_o, 1);
    cyc();
    check("raw_hazard", hazard_o, 1);
    check("raw_deq_blocked", deq_valid_o, 0);
    cyc();
    check("raw_hazard_held", hazard_o, 1);
    wb(1'b1, 5'd5, 1'b0);
    settle();
    check("raw_wb_release", deq_valid_o, 1);
    check("raw_wb_no_hazard", hazard_o, 0);
    cyc();
    wb(1'b0, 5'd0, 1'b0);
    settle();
    check("raw_count", count_o, 0);

    // File separation: pending f5 does not block integer x5.
    set_enq(mk(20), 1'b1, 5'd5, 1'b1, 15'd0, 3'b000, 3'b000);
    cyc();
    enq_off();
    cyc();
    set_enq(mk(21), 1'b0, 5'd0, 1'b0, 15'd5, 3'b001, 3'b000);
    cyc();
    enq_off();
    settle();
    check("fp_int_src_valid", deq_valid_o, 1);
    check("fp_int_src_hazard", hazard_o, 0);
    cyc();
    set_enq(mk(22), 1'b0, 5'd0, 1'b0, 15'd5, 3'b001, 3'b001);
    cyc();
    enq_off();
    settle();
    check("fp_src_hazard", hazard_o, 1);
    wb(1'b1, 5'd5, 1'b0);
    settle();
    check("fp_int_wb_no_clear", hazard_o, 1);
    wb(1'b1, 5'd5, 1'b1);
    settle();
    check("fp_wb_release", deq_valid_o, 1);
    cyc();
    wb(1'b0, 5'd0, 1'b0);

    // x0 writer never marks x0 busy.
    set_enq(mk(30), 1'b1, 5'd0, 1'b0, 15'd0, 3'b000, 3'b000);
    cyc();
    enq_off();
    cyc();
    set_enq(mk(31), 1'b1, 5'd0, 1'b0, 15'd0, 3'b001, 3'b000);
    cyc();
    enq_off();
    settle();
    check("x0_not_busy", deq_valid_o, 1);
    cyc();
    deq_ready_i = 1'b0;

    // Issue x7 writer in the writeback cycle of x7: the set wins.
    set_enq(mk(32), 1'b1, 5'd7, 1'b0, 15'd0, 3'b000, 3'b000);
    cyc();
    enq_off();
    settle();
    check("collide_writer_valid", deq_valid_o, 1);
    deq_ready_i = 1'b1;
    wb(1'b1, 5'd7, 1'b0);
    cyc();
    wb(1'b0, 5'd0, 1'b0);
    deq_ready_i = 1'b0;
    set_enq(mk(33), 1'b0, 5'd0, 1'b0, 15'(7 << 5), 3'b010, 3'b000);
    cyc();
    enq_off();
    settle();
    check("collide_x7_busy", hazard_o, 1);
    wb(1'b1, 5'd7, 1'b0);
    settle();
    check("collide_x7_release", deq_valid_o, 1);
    deq_ready_i = 1'b1;
    cyc();
    wb(1'b0, 5'd0, 1'b0);
    deq_ready_i = 1'b0;

    // Flush drops queued entries and the same-cycle enqueue, but keeps x9 busy.
    set_enq(mk(40), 1'b1, 5'd9, 1'b0, 15'd0, 3'b000, 3'b000);
    deq_ready_i = 1'b1;
    cyc();
    enq_off();
    cyc();
    deq_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_enq(mk(41 + i), 1'b0, 5'd0, 1'b0, 15'd0, 3'b000, 3'b000);
      cyc();
    end
    enq_off();
    settle();
    check("flush_pre_count", count_o, 3);
    set_enq(mk(44), 1'b0, 5'd0, 1'b0, 15'd0, 3'b000, 3'b000);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    enq_off();
    settle();
    check("flush_count", count_o, 0);
    check("flush_deq_valid", deq_valid_o, 0);
    check("flush_payload_zero", deq_payload_o, 0);
    set_enq(mk(45), 1'b0, 5'd0, 1'b0, 15'd9, 3'b001, 3'b000);
    cyc();
    enq_off();
    settle();
    check("flush_keeps_x9", hazard_o, 1);
    wb(1'b1, 5'd9, 1'b0);
    deq_ready_i = 1'b1;
    cyc();
    wb(1'b0, 5'd0, 1'b0);

    // Ten streaming enqueue/dequeue pairs wrap both pointers.
    for (int i = 0; i < 10; i++) begin
      set_enq(mk(50 + i), 1'b0, 5'd0, 1'b0, 15'd0, 3'b000, 3'b000);
      cyc();
      if (i > 0) check("wrap_count_steady", count_o, 1);
    end
    enq_off();
    cyc();
    check("wrap_count", count_o, 0);

    // Mid-cycle reset clears entries and busy bits without a clock edge.
    set_enq(mk(60), 1'b1, 5'd11, 1'b0, 15'd0, 3'b000, 3'b000);
    cyc();
    enq_off();
    cyc();
    deq_ready_i = 1'b0;
    set_enq(mk(61), 1'b0, 5'd0, 1'b0, 15'd0, 3'b000, 3'b000);
    cyc();
    set_enq(mk(62), 1'b0, 5'd0, 1'b0, 15'd0, 3'b000, 3'b000);
    cyc();
    enq_off();
    settle();
    check("prereset_count", count_o, 2);
    rst_n_i = 1'b0;
    #1;
    check("async_rst_count", count_o, 0);
    check("async_rst_enq_ready", enq_ready_o, 1);
    check("async_rst_deq_valid", deq_valid_o, 0);
    check("async_rst_hazard", hazard_o, 0);
    check("async_rst_payload", deq_payload_o, 0);
    cyc();
    rst_n_i = 1'b1;
    set_enq(mk(63), 1'b0, 5'd0, 1'b0, 15'd11, 3'b001, 3'b000);
    cyc();
    enq_off();
    settle();
    check("reset_clears_busy", deq_valid_o, 1);
    check("reset_clears_hazard", hazard_o, 0);
    deq_ready_i = 1'b1;
    cyc();
    deq_ready_i = 1'b0;
    cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32_d_issue_queue.md
RV32_D_ISSUE_QUEUE -- requirements
Module: rv32_d_issue_queue

Interface
REQ-001 Parameter PAYLOAD_W, default 256: width of the decoded control and operand bundle carried from decode to execute.
REQ-002 Parameter DEPTH, default 4: number of queue entries; SHALL be a power of two, 2..16.
REQ-003 Parameter FP_EN, default 1: when 0, the FP scoreboard is removed and all FP flags are ignored.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-006 flush_i  in  1  kill all queued, unissued entries.
REQ-007 enq_valid_i  in  1  decode offers an instruction.
REQ-008 enq_ready_o  out  1  queue can accept.
REQ-009 enq_payload_i  in  PAYLOAD_W  decoded bundle.
REQ-010 enq_wr_i  in  1  instruction writes a destination register.
REQ-011 enq_rd_i  in  5  destination register index.
REQ-012 enq_rd_fp_i  in  1  destination is in the FP file.
REQ-013 enq_rs_i  in  15  source indices {rs3, rs2, rs1}.
REQ-014 enq_rs_used_i  in  3  per-source used flags {rs3, rs2, rs1}.
REQ-015 enq_rs_fp_i  in  3  per-source FP-file flags {rs3, rs2, rs1}.
REQ-016 deq_valid_o  out  1  head entry is issuable.
REQ-017 deq_ready_i  in  1  execute accepts.
REQ-018 deq_payload_o  out  PAYLOAD_W  head payload.
REQ-019 wb_valid_i, wb_rd_i[4:0], wb_fp_i  in  1/5/1  writeback that retires a pending destination.
REQ-020 count_o  out  $clog2(DEPTH+1)  number of occupied entries.
REQ-021 hazard_o  out  1  queue is non-empty and the head is blocked by the scoreboard.

Function
REQ-022 The queue SHALL be an in-order circular FIFO with read and write pointers that wrap modulo DEPTH.
REQ-023 enq_ready_o SHALL equal (count_o != DEPTH) and SHALL NOT depend on a same-cycle dequeue (no full-pass-through).
REQ-024 An enqueue SHALL occur when enq_valid_i and enq_ready_o are both high.
REQ-025 A dequeue SHALL occur when deq_valid_o and deq_ready_i are both high.
REQ-026 A simultaneous enqueue and dequeue SHALL leave count_o unchanged.
REQ-027 Minimum latency SHALL be 1 cycle: an entry enqueued at edge N can be dequeued in the cycle after edge N; there is no empty bypass.
REQ-028 deq_payload_o SHALL show the head entry whenever the queue is non-empty, and SHALL be 0 when it is empty.
REQ-029 The scoreboard SHALL hold busy_int[31:0] and busy_fp[31:0]; busy_int[0] SHALL be constant 0.
REQ-030 The head SHALL be blocked when any used source, or its destination (if enq_wr_i was set), hits a busy bit in the matching file (WAW protection).
REQ-031 A same-cycle writeback to the same register SHALL clear the hit, so the head may issue in the writeback cycle.
REQ-032 deq_valid_o SHALL equal non-empty AND NOT blocked; hazard_o SHALL equal non-empty AND blocked.
REQ-033 On dequeue of a writing entry, the destination busy bit SHALL be set; an integer write to x0 SHALL NOT set any bit.
REQ-034 A writeback SHALL clear its busy bit; when a set and a clear hit the same bit in the same cycle, set SHALL win.
REQ-035 flush_i SHALL zero count_o and both pointers in one cycle, overriding any same-cycle enqueue or dequeue.
REQ-036 flush_i SHALL NOT alter the scoreboard, because already-issued instructions still write back.
REQ-037 A writeback to a register that is not busy SHALL have no effect.

Reset
REQ-038 While rst_n_i is low: pointers, count_o, storage, busy_int and busy_fp SHALL be 0; therefore enq_ready_o=1, deq_valid_o=0, hazard_o=0, deq_payload_o=0.
REQ-039 Reset asserted mid-operation SHALL discard all entries and all pending busy bits immediately, without waiting for a clock edge.

Verification
REQ-040 Fill/drain, DEPTH=4: 5 back-to-back enqueues with deq_ready_i=0 -> enq_ready_o=0 after 4; count_o=4; 5th not accepted. Then 4 dequeues -> payloads in order, count_o=0.
REQ-041 RAW stall: issue writer rd=x5, then head reads rs1=x5 -> hazard_o=1, deq_valid_o=0. wb x5 arrives -> deq_valid_o=1 in the same cycle.
REQ-042 File separation, FP_EN=1: pending FP f5, head reads integer x5 -> no hazard. Head reads f5 -> hazard until wb_fp_i=1, rd=5.
REQ-043 x0 and collision: writer rd=x0 issued -> busy_int unchanged. Issue writer x7 in the same cycle as wb x7 -> x7 remains busy.
REQ-044 Flush: 3 entries queued, x9 busy; flush_i together with enq_valid_i -> count_o=0 next cycle, new entry dropped, x9 still busy.
REQ-045 Wrap and reset: 10 enqueue/dequeue pairs cycle the pointers with payloads in order. Assert rst_n_i mid-stream -> outputs match REQ-038 asynchronously.
